// File: rtl/temp_pwm_gen.sv
// Temperature code capture from a ramp-counter/comparator pair, plus a PWM output whose duty
// follows the code. Define TEMP_PWM_AVG_EN to drive duty from a 4-code moving average.
`timescale 1ns/1ps
module temp_pwm_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] b,
  input  logic       cmp,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       ovf,
  output logic       pwm
);

  typedef enum logic [1:0] {StIdle, StArmed, StTripped} state_e;

  state_e     state_q, state_d;
  logic       cmp_meta_q, cmp_s_q, cmp_d_q;
  logic [7:0] prev_b_q;
  logic [7:0] cap_q, cap_d;
  logic [7:0] code_q, duty_q, duty_new;
  logic       ovf_q, code_valid_q, pwm_q;
  logic       trip, wrap;
  logic       publish, pub_ovf;
  logic [7:0] pub_code;

  assign trip = cmp_s_q & ~cmp_d_q;
  assign wrap = (prev_b_q == 8'hFF) && (b == 8'h00);

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    publish  = 1'b0;
    pub_code = 8'h00;
    pub_ovf  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // First wrap only marks the start of a full measurement period.
        if (wrap) state_d = StArmed;
      end
      StArmed: begin
        if (wrap) begin
          publish  = 1'b1;
          pub_code = 8'hFF;
          pub_ovf  = 1'b1;
        end else if (trip) begin
          cap_d   = b;
          state_d = StTripped;
        end
      end
      StTripped: begin
        if (wrap) begin
          publish  = 1'b1;
          pub_code = cap_q;
          state_d  = StArmed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef TEMP_PWM_AVG_EN
  logic [3:0][7:0] hist_q;
  logic [9:0]      sum_q, sum_d;

  // Running sum of the last four published codes; hist_q[3] is the oldest.
  assign sum_d    = sum_q - {2'b00, hist_q[3]} + {2'b00, pub_code};
  assign duty_new = sum_d[9:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      sum_q  <= '0;
    end else if (publish) begin
      hist_q <= {hist_q[2:0], pub_code};
      sum_q  <= sum_d;
    end
  end
`else
  assign duty_new = pub_code;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cmp_meta_q   <= 1'b0;
      cmp_s_q      <= 1'b0;
      cmp_d_q      <= 1'b0;
      prev_b_q     <= 8'h00;
      cap_q        <= 8'h00;
      code_q       <= 8'h00;
      ovf_q        <= 1'b0;
      code_valid_q <= 1'b0;
      duty_q       <= 8'h00;
      pwm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmp_meta_q   <= cmp;
      cmp_s_q      <= cmp_meta_q;
      cmp_d_q      <= cmp_s_q;
      prev_b_q     <= b;
      cap_q        <= cap_d;
      code_valid_q <= publish;
      if (publish) begin
        code_q <= pub_code;
        ovf_q  <= pub_ovf;
        duty_q <= duty_new;
      end
      // Compares against the duty in force before this edge, so a new duty starts at b=1.
      pwm_q <= (b < duty_q);
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign ovf        = ovf_q;
  assign pwm        = pwm_q;

endmodule

// File: doc/temp_pwm_gen.md
# temp_pwm_gen

Downstream consumer of the 8-bit ramp counter in the temperature-to-PWM path. The counter drives the ramp DAC, and the comparator trips when the ramp crosses the temperature-dependent voltage. This block does three things:
- captures the counter value at the comparator trip, once per ramp period, as the temperature code;
- publishes that code with a one-cycle valid strobe;
- drives a PWM output whose duty tracks the code, using the same counter as its timebase.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  system clock; same clock as the ramp counter.
- `reset`  in  1  asynchronous, active-low reset.
- `b`  in  8  ramp counter value; increments by 1 per `clk` and wraps 255→0.
- `cmp`  in  1  analog comparator output; asynchronous to `clk`.
- `code`  out  8  last captured temperature code.
- `code_valid`  out  1  one-cycle pulse when `code` updates.
- `ovf`  out  1  last period had no trip; `code` was forced to 255.
- `pwm`  out  1  PWM output.

## Operation
- Synchroniser: `cmp` passes through a 2-flop chain to give `cmp_s`, then a delay flop gives `cmp_d`. A trip is `cmp_s & ~cmp_d` (rising edge only).
- Wrap detect: a registered `prev_b` is kept. `wrap` = (`prev_b`==8'hFF && `b`==8'h00).
  - A counter held at 0 (upstream in reset) never produces `wrap`.
- FSM states and transitions:
  - IDLE (reset state): ignores trips. On `wrap` → ARMED; no code is published.
  - ARMED: on trip (not coincident with `wrap`), `cap` <= `b` and → TRIPPED.
  - ARMED on `wrap`: `code` <= 8'hFF, `ovf` <= 1, `code_valid` <= 1; stays ARMED.
  - TRIPPED: further trips are ignored. On `wrap`: `code` <= `cap`, `ovf` <= 0, `code_valid` <= 1; → ARMED.
- A trip on the same cycle as `wrap` is discarded. It does not count for either period.
- Captured code is the raw `b` at the detect cycle. No compensation for synchroniser latency; the analog trim absorbs it.
- Duty:
  - `duty` is loaded on the same edge that loads `code` (the `wrap` edge), so duty changes only at the period boundary.
  - `duty` = new code, or the average value (see Configuration).
- PWM: `pwm` <= (`b` < `duty`), registered.
  - `duty`=0 → `pwm` constantly 0.
  - `duty`=255 → `pwm` high for 255 of 256 cycles.
- Reset assertion mid-period aborts the measurement and returns everything to the reset values. This is asynchronous; no partial code is published.

## Timing
- Reset values: `code`=0, `code_valid`=0, `ovf`=0, `pwm`=0, `duty`=0, `cap`=0, `prev_b`=0, all synchroniser flops 0, FSM=IDLE.
- `cmp` edge to trip detect: 2–3 `clk` cycles.
- `code`, `ovf`, `duty` and `code_valid` change on the rising edge at the end of the `wrap` cycle. That is the edge where `b` goes 0→1.
- `code_valid` is high for exactly one cycle per period (every 256 cycles), starting from the second wrap after reset.
- `pwm` lags `b` by one cycle. The first period using a new `duty` starts at `b`=1 registered, i.e. `pwm` reflects `b`=0 of the next period.

## Configuration
- `TEMP_PWM_AVG_EN` defined:
  - A 4-entry shift register holds the last 4 published codes, reset to 0; overflow codes (255) are included.
  - A 10-bit sum is kept; `duty` = sum[9:2], computed with the new code included, loaded at `wrap`.
  - The first three published periods after reset average against zeros.
- `TEMP_PWM_AVG_EN` undefined: `duty` = new `code` directly; no averaging logic is instantiated.
- `code`, `ovf` and `code_valid` are identical in both builds.

## Test plan
- Reset, free-running `b`, `cmp`=0: first `wrap` → no `code_valid`. Second `wrap` → `code_valid` pulse with `code`=255, `ovf`=1; `pwm` high 255/256 cycles (non-AVG).
- `cmp` rises while `b`=99 each period: detect lands at `b`=101 or 102 (sync latency). `code` is 101 or 102 and constant across periods, `ovf`=0. `pwm` high for `code` cycles per 256 (non-AVG).
- `cmp` toggles three times in one period (rises at `b`=40, 80, 120): `code` = first-edge capture only (~42); later edges are ignored.
- Trip edge detected exactly on the `wrap` cycle: no capture. Next published `code`=255, `ovf`=1 unless another edge occurs in that period.
- With `TEMP_PWM_AVG_EN`, codes 200, 200, 200, 200: `duty` sequence 50, 100, 150, 200. Then one period with no trip (code 255) → `duty`=213.
- Deassert→assert `reset` at `b`=150 in a TRIPPED period: all outputs return to reset values immediately, with no `code_valid`. After release, publishing resumes from the second observed `wrap`.
